// File: rtl/alien_sprite_unit.sv
// alien_sprite_unit: walking alien sprite with bullet hit detection and VGA pixel raster (optional ALIEN_BITMAP_EN mask)
module alien_sprite_unit #(
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int SPR_W     = 10,
  parameter int SPR_H     = 4,
  parameter int START_X   = 180,
  parameter int START_Y   = 10,
  parameter int START_DIR = 0,
  parameter int MIN_X     = 0,
  parameter int MAX_X     = 319,
  parameter int STEP      = 1,
  parameter int DROP      = 1,
  parameter logic [2:0] COLOUR = 3'b101,
  parameter logic [SPR_W*SPR_H-1:0] BITMAP = '1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           move_tick,
  input  logic           draw_req,
  input  logic           erase_req,
  input  logic           bullet_valid,
  input  logic [X_W-1:0] bullet_x,
  input  logic [Y_W-1:0] bullet_y,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     colour,
  output logic           plot,
  output logic           busy,
  output logic           finish,
  output logic           collision
);
  typedef enum logic [1:0] {IDLE, DRAW, ERASE} state_e;
  state_e state_q, state_d;
  logic [X_W-1:0] pos_x_q, pos_x_d, base_x_q, base_x_d, x_q, x_d;
  logic [Y_W-1:0] pos_y_q, pos_y_d, base_y_q, base_y_d, y_q, y_d;
  logic [5:0] col_q, col_d, row_q, row_d, col_n, row_n;
  logic [2:0] colour_q, colour_d;
  logic plot_q, plot_d, finish_q, finish_d, coll_q, hit_q, hit_c, rise;
  logic dir_q, dir_d, pending_q, pending_d, respawn, last, bm0, bmn;
  logic [X_W:0] right_edge;
  logic [Y_W:0] y_drop;
  assign col_n = (col_q == 6'(SPR_W - 1)) ? '0 : col_q + 6'd1;
  assign row_n = (col_q == 6'(SPR_W - 1)) ? row_q + 6'd1 : row_q;
  assign last = (col_q == 6'(SPR_W - 1)) && (row_q == 6'(SPR_H - 1));
`ifdef ALIEN_BITMAP_EN
  localparam int IW = (SPR_W * SPR_H > 1) ? $clog2(SPR_W * SPR_H) : 1;
  logic [IW-1:0] idx_n;
  assign idx_n = IW'(32'(row_n) * SPR_W + 32'(col_n));
  assign bm0 = BITMAP[0];
  assign bmn = BITMAP[idx_n];
`else
  assign bm0 = 1'b1;
  assign bmn = 1'b1;
`endif
  // Raster FSM: snapshot position on entry, then emit one registered pixel per cycle
  always_comb begin
    state_d = state_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    col_d = col_q;
    row_d = row_q;
    x_d = x_q;
    y_d = y_q;
    colour_d = colour_q;
    plot_d = 1'b0;
    finish_d = 1'b0;
    if (state_q == IDLE) begin
      if (draw_req || erase_req) begin
        state_d = erase_req ? ERASE : DRAW;
        base_x_d = pos_x_q;
        base_y_d = pos_y_q;
        col_d = '0;
        row_d = '0;
        x_d = pos_x_q;
        y_d = pos_y_q;
        colour_d = erase_req ? 3'b000 : COLOUR;
        plot_d = erase_req || bm0;
      end
    end else if (last) begin
      state_d = IDLE;
      finish_d = 1'b1;
    end else begin
      col_d = col_n;
      row_d = row_n;
      x_d = base_x_q + X_W'(col_n);
      y_d = base_y_q + Y_W'(row_n);
      plot_d = (state_q == ERASE) || bmn;
    end
  end
  assign right_edge = {1'b0, pos_x_q} + (X_W+1)'(STEP + SPR_W - 1);
  assign y_drop = {1'b0, pos_y_q} + (Y_W+1)'(DROP);
  assign hit_c = bullet_valid
    && ({1'b0, bullet_x} >= {1'b0, pos_x_q})
    && ({1'b0, bullet_x} <= {1'b0, pos_x_q} + (X_W+1)'(SPR_W - 1))
    && ({1'b0, bullet_y} >= {1'b0, pos_y_q})
    && ({1'b0, bullet_y} <= {1'b0, pos_y_q} + (Y_W+1)'(SPR_H - 1));
  assign rise = hit_c && !hit_q;
  assign respawn = (state_q == IDLE) && pending_q;
  // Movement, edge drop/reverse and deferred respawn after a hit
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    dir_d = dir_q;
    pending_d = pending_q || rise;
    if (respawn) begin
      pos_x_d = X_W'(START_X);
      pos_y_d = Y_W'(START_Y);
      dir_d = 1'(START_DIR);
      pending_d = rise;
    end else if (move_tick) begin
      if (dir_q ? (right_edge > (X_W+1)'(MAX_X)) : ({1'b0, pos_x_q} < (X_W+1)'(MIN_X + STEP))) begin
        pos_y_d = y_drop[Y_W] ? '1 : y_drop[Y_W-1:0];
        dir_d = !dir_q;
      end else begin
        pos_x_d = dir_q ? pos_x_q + X_W'(STEP) : pos_x_q - X_W'(STEP);
      end
    end
  end
  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pos_x_q <= X_W'(START_X);
      pos_y_q <= Y_W'(START_Y);
      dir_q <= 1'(START_DIR);
      pending_q <= 1'b0;
      base_x_q <= '0;
      base_y_q <= '0;
      col_q <= '0;
      row_q <= '0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= '0;
      plot_q <= 1'b0;
      finish_q <= 1'b0;
      hit_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dir_q <= dir_d;
      pending_q <= pending_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      col_q <= col_d;
      row_q <= row_d;
      x_q <= x_d;
      y_q <= y_d;
      colour_q <= colour_d;
      plot_q <= plot_d;
      finish_q <= finish_d;
      hit_q <= hit_c;
      coll_q <= rise;
    end
  end
  assign x = x_q;
  assign y = y_q;
  assign colour = colour_q;
  assign plot = plot_q;
  assign busy = (state_q != IDLE);
  assign finish = finish_q;
  assign collision = coll_q;
endmodule
